// File: rtl/core_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding imem request, PC-advance strobe,
// branch redirect with squash of in-flight responses, one-entry decode buffer.
module core_fetch_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fetch_en_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_write_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  input  logic            branch_taken_i,
  input  logic [XLEN-1:0] pc_branch_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            id_ready_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              redir_q, redir_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              is_redir_q, is_redir_d;
  logic              discard_q, discard_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   instr_pc_q, instr_pc_d;

  logic [XLEN-1:0]   fetch_addr;
  logic              fetch_redir;
  logic              load;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      is_redir_q <= 1'b0;
      discard_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      is_redir_q <= is_redir_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    addr_d        = addr_q;
    redir_d       = redir_q;
    redir_pc_d    = redir_pc_q;
    is_redir_d    = is_redir_q;
    discard_d     = discard_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    imem_req_o    = 1'b0;
    pc_write_o    = 1'b0;
    redirect_o    = 1'b0;
    load          = 1'b0;

    // A held request keeps its latched address; otherwise point at the next fetch
    fetch_addr    = req_q ? addr_q : (redir_q ? redir_pc_q : pc_i);
    fetch_redir   = req_q ? is_redir_q : redir_q;
    imem_addr_o   = fetch_addr;
    redirect_pc_o = addr_q;

    case (state_q)
      IDLE: begin
        if (fetch_en_i) state_d = REQ;
      end
      REQ: begin
        if (req_q || (fetch_en_i && (!valid_q || id_ready_i) && !branch_taken_i)) begin
          imem_req_o    = 1'b1;
          req_d         = 1'b1;
          addr_d        = fetch_addr;
          is_redir_d    = fetch_redir;
          redirect_pc_o = fetch_addr;
          if (imem_gnt_i) begin
            pc_write_o = 1'b1;
            redirect_o = fetch_redir;
            req_d      = 1'b0;
            state_d    = WAIT;
            if (fetch_redir && !branch_taken_i) redir_d = 1'b0;
          end
        end else if (!fetch_en_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          load      = !discard_q && !branch_taken_i;
          discard_d = 1'b0;
          state_d   = fetch_en_i ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata_i;
      instr_pc_d = addr_q;
    end else if (valid_q && id_ready_i) begin
      valid_d = 1'b0;
    end

    // Branch squashes the buffer and any fetch whose response is still outstanding
    if (branch_taken_i) begin
      redir_d    = 1'b1;
      redir_pc_d = pc_branch_i;
      valid_d    = 1'b0;
      if ((state_q == WAIT && !imem_rvalid_i) || (state_q == REQ && imem_req_o))
        discard_d = 1'b1;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;

endmodule

// File: tb/tb_core_fetch_ctrl.sv
// Directed bench for core_fetch_ctrl: hand-computed expectations per cycle,
// inputs driven on the falling edge and outputs sampled 1ns later.
module tb_core_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] pc;
  logic        pc_write;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;

  int passed = 0;
  int total  = 0;

  core_fetch_ctrl #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .fetch_en_i     (fetch_en),
    .pc_i           (pc),
    .pc_write_o     (pc_write),
    .redirect_o     (redirect),
    .redirect_pc_o  (redirect_pc),
    .branch_taken_i (branch_taken),
    .pc_branch_i    (pc_branch),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_gnt_i     (imem_gnt),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
    .instr_valid_o  (instr_valid),
    .instr_o        (instr),
    .instr_pc_o     (instr_pc),
    .id_ready_i     (id_ready)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: drive inputs after the falling edge, let combinational paths settle
  task automatic step(input logic fe, input logic gnt, input logic rv, input logic [31:0] rdata,
                      input logic rdy, input logic br, input logic [31:0] pcb, input logic [31:0] pcv);
    @(negedge clk);
    fetch_en     = fe;
    imem_gnt     = gnt;
    imem_rvalid  = rv;
    imem_rdata   = rdata;
    id_ready     = rdy;
    branch_taken = br;
    pc_branch    = pcb;
    pc           = pcv;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk1 ({tag, "_req"},     imem_req,    1'b0);
    chk1 ({tag, "_pcw"},     pc_write,    1'b0);
    chk1 ({tag, "_redir"},   redirect,    1'b0);
    chk1 ({tag, "_valid"},   instr_valid, 1'b0);
    chk32({tag, "_instr"},   instr,       32'h0);
    chk32({tag, "_ipc"},     instr_pc,    32'h0);
    chk32({tag, "_rpc"},     redirect_pc, 32'h0);
    chk32({tag, "_addr"},    imem_addr,   pc);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_en = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; branch_taken = 1'b0; pc_branch = '0; pc = 32'h4000_0000;

    // Reset values
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk_reset("rst0");
    rst_n = 1'b1;

    // IDLE: no request in the first enabled cycle
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk1("idle_req", imem_req, 1'b0);

    // First fetch, granted immediately
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk1 ("f0_req",   imem_req,    1'b1);
    chk32("f0_addr",  imem_addr,   32'h4000_0000);
    chk1 ("f0_pcw",   pc_write,    1'b1);
    chk1 ("f0_redir", redirect,    1'b0);
    chk32("f0_rpc",   redirect_pc, 32'h4000_0000);

    step(1'b1, 1'b0, 1'b1, 32'hAAAA_0001, 1'b1, 1'b0, 32'h0, 32'h4000_0004);
    chk1("f0_wait_req", imem_req, 1'b0);
    chk1("f0_wait_pcw", pc_write, 1'b0);

    // Delivery two cycles after the request, with the next request alongside
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0004);
    chk1 ("f0_valid", instr_valid, 1'b1);
    chk32("f0_instr", instr,       32'hAAAA_0001);
    chk32("f0_ipc",   instr_pc,    32'h4000_0000);
    chk1 ("f1_req",   imem_req,    1'b1);
    chk32("f1_addr",  imem_addr,   32'h4000_0004);
    chk1 ("f1_pcw",   pc_write,    1'b1);

    step(1'b1, 1'b0, 1'b1, 32'hAAAA_0002, 1'b1, 1'b0, 32'h0, 32'h4000_0008);
    chk1("f1_consumed", instr_valid, 1'b0);

    // Next delivery; grant now held off for three cycles
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0008);
    chk1 ("f1_valid", instr_valid, 1'b1);
    chk32("f1_ipc",   instr_pc,    32'h4000_0004);
    chk1 ("d0_req",   imem_req,    1'b1);
    chk32("d0_addr",  imem_addr,   32'h4000_0008);
    chk1 ("d0_pcw",   pc_write,    1'b0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h5000_0000);
    chk1 ("d1_req",  imem_req,  1'b1);
    chk32("d1_addr", imem_addr, 32'h4000_0008);
    chk1 ("d1_pcw",  pc_write,  1'b0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h5000_0000);
    chk1 ("d2_req",  imem_req,  1'b1);
    chk32("d2_addr", imem_addr, 32'h4000_0008);
    chk1 ("d2_pcw",  pc_write,  1'b0);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_000C);
    chk1 ("d3_req",  imem_req,    1'b1);
    chk32("d3_addr", imem_addr,   32'h4000_0008);
    chk1 ("d3_pcw",  pc_write,    1'b1);
    chk32("d3_rpc",  redirect_pc, 32'h4000_0008);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4000_000C);
    chk1("d_wait_pcw", pc_write, 1'b0);

    step(1'b1, 1'b0, 1'b1, 32'hAAAA_0003, 1'b0, 1'b0, 32'h0, 32'h4000_000C);

    // Decode stalled with a full buffer: no request, instruction held
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4000_000C);
    chk1 ("stall0_valid", instr_valid, 1'b1);
    chk32("stall0_instr", instr,       32'hAAAA_0003);
    chk32("stall0_ipc",   instr_pc,    32'h4000_0008);
    chk1 ("stall0_req",   imem_req,    1'b0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4000_000C);
    chk32("stall1_instr", instr,    32'hAAAA_0003);
    chk1 ("stall1_req",   imem_req, 1'b0);

    // Release: request issues in the same cycle
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_000C);
    chk1 ("rel_req",  imem_req,  1'b1);
    chk32("rel_addr", imem_addr, 32'h4000_000C);
    chk1 ("rel_pcw",  pc_write,  1'b1);

    // Branch while waiting: in-flight response squashed
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4000_0100, 32'h4000_0010);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_0000, 1'b1, 1'b0, 32'h0, 32'h4000_0010);
    chk1("br_valid0", instr_valid, 1'b0);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0010);
    chk1 ("br_drop",   instr_valid, 1'b0);
    chk1 ("br_req",    imem_req,    1'b1);
    chk32("br_addr",   imem_addr,   32'h4000_0100);
    chk1 ("br_pcw",    pc_write,    1'b1);
    chk1 ("br_redir",  redirect,    1'b1);
    chk32("br_rpc",    redirect_pc, 32'h4000_0100);

    step(1'b1, 1'b0, 1'b1, 32'hBBBB_0100, 1'b1, 1'b0, 32'h0, 32'h4000_0104);

    // Delivery of the target; then two back-to-back branches
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'h4000_0104);
    chk1 ("tgt_valid", instr_valid, 1'b1);
    chk32("tgt_instr", instr,       32'hBBBB_0100);
    chk32("tgt_ipc",   instr_pc,    32'h4000_0100);
    chk1 ("bb0_req",   imem_req,    1'b0);

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0200, 32'h4000_0104);
    chk1 ("bb1_req",   imem_req,    1'b0);
    chk1 ("bb1_valid", instr_valid, 1'b0);
    chk32("bb1_addr",  imem_addr,   32'h0000_0100);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0104);
    chk1 ("bb2_req",   imem_req,    1'b1);
    chk32("bb2_addr",  imem_addr,   32'h0000_0200);
    chk1 ("bb2_redir", redirect,    1'b1);
    chk32("bb2_rpc",   redirect_pc, 32'h0000_0200);
    chk1 ("bb2_valid", instr_valid, 1'b0);

    step(1'b1, 1'b0, 1'b1, 32'hCCCC_0200, 1'b1, 1'b0, 32'h0, 32'h0000_0204);
    chk1("bb3_valid", instr_valid, 1'b0);

    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0000_0204);
    chk1 ("bb4_valid", instr_valid, 1'b1);
    chk32("bb4_ipc",   instr_pc,    32'h0000_0200);
    chk32("bb4_instr", instr,       32'hCCCC_0200);
    chk32("bb4_addr",  imem_addr,   32'h0000_0204);
    chk1 ("bb4_redir", redirect,    1'b0);

    // Reset while waiting on a response
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk_reset("rst2");
    rst_n = 1'b1;

    // Restart from pc_i
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h4000_0000);
    chk1 ("rs_req",   imem_req,  1'b1);
    chk32("rs_addr",  imem_addr, 32'h4000_0000);
    chk1 ("rs_pcw",   pc_write,  1'b1);
    chk1 ("rs_redir", redirect,  1'b0);

    step(1'b1, 1'b0, 1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0, 32'h4000_0004);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4000_0004);
    chk1 ("rs_valid", instr_valid, 1'b1);
    chk32("rs_ipc",   instr_pc,    32'h4000_0000);
    chk32("rs_instr", instr,       32'h1111_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
